// File: rtl/comp_dict_pkg.sv
// rtl/comp_dict_pkg.sv - shared command, response and FSM state types for the dictionary compressor
package comp_dict_pkg;

  typedef enum logic [1:0] {
    NOP        = 2'b00,
    COMPRESS   = 2'b01,
    DECOMPRESS = 2'b10,
    FLUSH      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    COMP_OK   = 2'b01,
    DECOMP_OK = 2'b10,
    ERROR     = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    READ   = 2'b10,
    RESP   = 2'b11
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/comp_dict_mem.sv
// rtl/comp_dict_mem.sv - dictionary storage, one write port and one registered read port, no reset
module comp_dict_mem #(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/comp_dict_engine.sv
// rtl/comp_dict_engine.sv - dictionary compress/decompress engine; COMP_DICT_STATS_EN adds hit/miss counters
module comp_dict_engine
  import comp_dict_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        command,
  input  logic [DATA_W-1:0] data_in,
  input  logic [IDX_W-1:0]  compressed_in,
  output logic [IDX_W-1:0]  compressed_out,
  output logic [DATA_W-1:0] decompressed_out,
  output logic [1:0]        response,
`ifdef COMP_DICT_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  output logic              busy
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  state_e              state_q, state_d;
  resp_e               resp_q, resp_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [IDX_W:0]      idx_q, idx_d, idx_nxt;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    tok_q, tok_d;
  logic [IDX_W-1:0]    cout_q, cout_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;
  cmd_e                cmd;

  assign cmd     = cmd_e'(command);
  assign idx_nxt = idx_q + 1'b1;

  comp_dict_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (count_q[IDX_W-1:0]),
    .wdata_i (data_q),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // The read port is always one entry ahead so entry idx_q is on mem_rdata while in SEARCH.
  always_comb begin
    state_d   = state_q;
    resp_d    = NONE;
    count_d   = count_q;
    idx_d     = idx_q;
    data_d    = data_q;
    tok_d     = tok_q;
    cout_d    = cout_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_raddr = '0;
    case (state_q)
      IDLE: begin
        case (cmd)
          COMPRESS: begin
            data_d  = data_in;
            idx_d   = '0;
            state_d = SEARCH;
          end
          DECOMPRESS: begin
            tok_d     = compressed_in;
            mem_raddr = compressed_in;
            state_d   = READ;
          end
          FLUSH:   count_d = '0;
          default: ;
        endcase
      end
      SEARCH: begin
        mem_raddr = idx_nxt[IDX_W-1:0];
        idx_d     = idx_nxt;
        if (idx_q < count_q) begin
          if (mem_rdata == data_q) begin
            cout_d  = idx_q[IDX_W-1:0];
            resp_d  = COMP_OK;
            state_d = RESP;
          end
        end else begin
          state_d = RESP;
          if (count_q < FULL) begin
            mem_we  = 1'b1;
            cout_d  = count_q[IDX_W-1:0];
            count_d = count_q + 1'b1;
            resp_d  = COMP_OK;
          end else begin
            resp_d = ERROR;
          end
        end
      end
      READ: begin
        state_d = RESP;
        if ({1'b0, tok_q} < count_q) begin
          dout_d = mem_rdata;
          resp_d = DECOMP_OK;
        end else begin
          resp_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      resp_q  <= NONE;
      count_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tok_q   <= '0;
      cout_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tok_q   <= tok_d;
      cout_q  <= cout_d;
      dout_q  <= dout_d;
    end
  end

  assign compressed_out   = cout_q;
  assign decompressed_out = dout_q;
  assign response         = resp_q;
  assign busy             = (state_q != IDLE);

`ifdef COMP_DICT_STATS_EN
  logic [STAT_W-1:0] hit_q, miss_q;
  logic              comp_done, comp_hit;

  // A hit is a successful compress that did not need to write a new entry.
  assign comp_done = (state_q == SEARCH) && (state_d == RESP);
  assign comp_hit  = (resp_d == COMP_OK) && !mem_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == IDLE && cmd == FLUSH) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (comp_done) begin
      if (comp_hit) begin
        if (hit_q != '1) hit_q <= hit_q + 1'b1;
      end else begin
        if (miss_q != '1) miss_q <= miss_q + 1'b1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

endmodule

// File: doc/comp_dict_engine.md
COMP_DICT_ENGINE -- requirements
Module: comp_dict_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 80, uncompressed word width.
REQ-002 SHALL have parameter DEPTH, default 256, dictionary entries, power of two, at least 2.
REQ-003 SHALL have localparam IDX_W = $clog2(DEPTH), compressed token width (8 at default).
REQ-004 Port: clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-low reset.
REQ-006 Port: command, input, 2, 00 nop, 01 compress, 10 decompress, 11 flush dictionary.
REQ-007 Port: data_in, input, DATA_W, word to compress; sampled on acceptance.
REQ-008 Port: compressed_in, input, IDX_W, token to decompress; sampled on acceptance.
REQ-009 Port: compressed_out, output, IDX_W, token result of last compress.
REQ-010 Port: decompressed_out, output, DATA_W, word result of last decompress.
REQ-011 Port: response, output, 2, 00 none, 01 compress done, 10 decompress done, 11 error; one-cycle pulse.
REQ-012 Port: busy, output, 1, high while a command is in progress; commands are ignored while high.

Function
REQ-013 Command SHALL be accepted on cycle N when command!=00 and busy=0; busy SHALL be high from N+1 until the response cycle, inclusive.
REQ-014 FSM states SHALL be IDLE, SEARCH, READ and RESP: IDLE->SEARCH on compress, IDLE->READ on decompress, SEARCH/READ->RESP, RESP->IDLE.
REQ-015 Compress SHALL scan entries 0..count-1, one per cycle, starting at N+1.
REQ-016 On first match at entry k, compressed_out=k and response=01 SHALL occur at cycle N+2+k.
REQ-017 On miss with count<DEPTH, data SHALL be written at entry count, count SHALL increment, and compressed_out=old count with response=01 SHALL occur at N+2+count.
REQ-018 On miss with count==DEPTH, response SHALL be 11, compressed_out SHALL be unchanged and the dictionary SHALL be unchanged.
REQ-019 Empty dictionary (count=0) SHALL miss immediately, with response at N+2.
REQ-020 Decompress with compressed_in<count SHALL give decompressed_out=entry and response=10 at N+2.
REQ-021 Decompress with compressed_in>=count SHALL give response=11 at N+2, with decompressed_out unchanged.
REQ-022 Flush SHALL set count=0 at N+1, keep busy low, and produce no response; entry contents need not be cleared.
REQ-023 compressed_out and decompressed_out SHALL hold their values between responses.
REQ-024 count SHALL be IDX_W+1 bits wide and SHALL never exceed DEPTH; no wrap-around.

Reset
REQ-025 reset low SHALL asynchronously force state=IDLE, count=0, busy=0, response=00, compressed_out=0 and decompressed_out=0.
REQ-026 Reset mid-operation SHALL abort the command with no response and no dictionary write.
REQ-027 Dictionary storage SHALL NOT require reset.

Configuration
REQ-028 With macro COMP_DICT_STATS_EN defined, the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0], counting compress hits and misses (including full misses), saturating at 16'hFFFF, and cleared by reset and by flush.
REQ-029 Without COMP_DICT_STATS_EN, the stats ports and counters SHALL be absent, with identical remaining behaviour.

Structure
REQ-030 Package comp_dict_pkg SHALL hold the cmd_e enum (NOP, COMPRESS, DECOMPRESS, FLUSH), the resp_e enum (NONE, COMP_OK, DECOMP_OK, ERROR) and the FSM state enum.
REQ-031 Storage SHALL be sub-module comp_dict_mem (DEPTH x DATA_W, one registered read port, one write port).

Verification (DATA_W=80, DEPTH=4)
REQ-032 Compress 80'hA after reset -> response=01, compressed_out=0 at N+2; busy high for cycles N+1..N+2.
REQ-033 Compress 80'hA, 80'hB, then 80'hB again -> tokens 0, 1, 1; third response arrives at N+3 (hit at k=1).
REQ-034 Fill 4 distinct words, then compress a 5th new word -> response=11 at N+6, compressed_out unchanged; decompress token 3 -> 4th word, response=10.
REQ-035 Decompress token 2 with count=1 -> response=11 and decompressed_out unchanged; then flush and decompress 0 -> response=11.
REQ-036 Assert reset during SEARCH, then release and compress the same word -> no response before reset, then token 0 after release.
REQ-037 Issue a decompress command while busy=1 -> the command is ignored and only the original command's response is produced.
